sc_ulpi_reg_ctrl: RTL

//  Register-access sequencer for the link side of a ULPI PHY interface. Takes one read/write request at a

---
 rtl/sc_ulpi_reg_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sc_ulpi_reg_ctrl.sv
// sc_ulpi_reg_ctrl -- link-side ULPI register access sequencer.
//
// Accepts one register read/write request at a time from the SCBC control
// logic and runs it on the ULPI bus. The sequence is TX CMD, then an optional
// extended address, then either write data followed by STP, or a read
// turnaround followed by the data byte from the PHY. A PHY abort (dir rising
// while the link drives, or nxt during read data) causes the request to be
// retried. When the bus is otherwise idle, RX CMD bytes are captured.
//
// Ports:
//   CLK, RSTN           60 MHz ULPI clock, async active-low reset
//   REQ/REQ_WR/REQ_ADDR/REQ_WDATA   request, held stable until ACK
//   ACK/ERR/RDATA       completion pulse, error flag, read data
//   ULPI_DIR/NXT/DATA_I PHY-driven bus signals
//   ULPI_DATA_O/OE/STP  link-driven bus signals
//   RXCMD/RXCMD_VLD     last RX CMD byte and its update pulse
module sc_ulpi_reg_ctrl #(
    parameter int TIMEOUT_CYC = 256,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       REQ,
    input  logic       REQ_WR,
    input  logic [7:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic       ACK,
    output logic       ERR,
    output logic [7:0] RDATA,
    input  logic       ULPI_DIR,
    input  logic       ULPI_NXT,
    input  logic [7:0] ULPI_DATA_I,
    output logic [7:0] ULPI_DATA_O,
    output logic       ULPI_DATA_OE,
    output logic       ULPI_STP,
    output logic [7:0] RXCMD,
    output logic       RXCMD_VLD
);

    typedef enum logic [3:0] {
        IDLE, TURN, TXCMD, TXEAD, TXDATA, STP, RD_TURN, RD_DATA, RD_END, RX, DONE
    } state_e;

    typedef struct packed {
        logic       altInt;
        logic       id;
        logic [1:0] rxEvent;
        logic [1:0] vbusState;
        logic [1:0] lineState;
    } rxCmd_s;

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_e        state;
    logic [TW-1:0] toCnt;
    logic [RW-1:0] retryCnt;
    logic          isWr, isExt, toErr, drive;
    logic [7:0]    addr, wdata, rdBuf;
    rxCmd_s        rxCmd;

    logic       reqExt, timeout, retryOver;
    logic [7:0] reqCmd;

    assign reqExt    = (REQ_ADDR > 8'h3F) || (REQ_ADDR == 8'h2F);
    assign reqCmd    = {REQ_WR ? 2'b10 : 2'b11, reqExt ? 6'h2F : REQ_ADDR[5:0]};
    assign timeout   = (toCnt == TO_LAST);
    assign retryOver = (retryCnt > RETRY_LIM);

    // Gated combinationally so the link releases the bus in the very cycle
    // the PHY takes it.
    assign ULPI_DATA_OE = drive & ~ULPI_DIR;
    assign RXCMD        = rxCmd;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            toCnt       <= '0;
            retryCnt    <= '0;
            isWr        <= 1'b0;
            isExt       <= 1'b0;
            toErr       <= 1'b0;
            drive       <= 1'b0;
            addr        <= 8'h00;
            wdata       <= 8'h00;
            rdBuf       <= 8'h00;
            rxCmd       <= '0;
            ACK         <= 1'b0;
            ERR         <= 1'b0;
            RDATA       <= 8'h00;
            ULPI_DATA_O <= 8'h00;
            ULPI_STP    <= 1'b0;
            RXCMD_VLD   <= 1'b0;
        end else begin
            // Timer only runs while waiting in a timed state; any exit clears it.
            toCnt     <= '0;
            ACK       <= 1'b0;
            RXCMD_VLD <= 1'b0;
            case (state)
                IDLE: begin
                    if (ULPI_DIR) begin
                        state <= RX;    // this cycle is the turnaround
                    end else if (REQ && retryOver) begin
                        state <= DONE;
                        ACK   <= 1'b1;
                        ERR   <= 1'b1;
                    end else if (REQ) begin
                        // Also the restart point after an abort; REQ is stable.
                        state       <= TXCMD;
                        isWr        <= REQ_WR;
                        isExt       <= reqExt;
                        addr        <= REQ_ADDR;
                        wdata       <= REQ_WDATA;
                        toErr       <= 1'b0;
                        drive       <= 1'b1;
                        ULPI_DATA_O <= reqCmd;
                    end
                end
                TURN: state <= IDLE;
                TXCMD, TXEAD, TXDATA: begin
                    if (ULPI_DIR) begin
                        state       <= RX;
                        retryCnt    <= retryCnt + RW'(1);
                        drive       <= 1'b0;
                        ULPI_DATA_O <= 8'h00;
                    end else if (ULPI_NXT) begin
                        if (state == TXCMD && isExt) begin
                            state       <= TXEAD;
                            ULPI_DATA_O <= addr;
                        end else if (state != TXDATA && isWr) begin
                            state       <= TXDATA;
                            ULPI_DATA_O <= wdata;
                        end else if (state != TXDATA) begin
                            state       <= RD_TURN;
                            ULPI_DATA_O <= 8'h00;
                        end else begin
                            state       <= STP;
                            ULPI_STP    <= 1'b1;
                            ULPI_DATA_O <= 8'h00;
                        end
                    end else if (timeout) begin
                        state       <= STP;
                        toErr       <= 1'b1;
                        ULPI_STP    <= 1'b1;
                        ULPI_DATA_O <= 8'h00;
                    end else begin
                        toCnt <= toCnt + TW'(1);
                    end
                end
                STP: begin
                    state    <= DONE;
                    ULPI_STP <= 1'b0;
                    drive    <= 1'b0;
                    ACK      <= 1'b1;
                    ERR      <= toErr;
                end
                RD_TURN: begin
                    if (ULPI_DIR) begin
                        state <= RD_DATA;
                        drive <= 1'b0;
                    end else if (timeout) begin
                        state <= DONE;
                        drive <= 1'b0;
                        ACK   <= 1'b1;
                        ERR   <= 1'b1;
                    end else begin
                        toCnt <= toCnt + TW'(1);
                    end
                end
                RD_DATA: begin
                    // nxt here means the PHY switched to USB receive data;
                    // dir dropping means it gave up on the read.
                    if (!ULPI_DIR) begin
                        state    <= TURN;
                        retryCnt <= retryCnt + RW'(1);
                    end else if (ULPI_NXT) begin
                        state    <= RX;
                        retryCnt <= retryCnt + RW'(1);
                    end else begin
                        state <= RD_END;
                        rdBuf <= ULPI_DATA_I;
                    end
                end
                RD_END: begin
                    if (!ULPI_DIR) begin
                        state <= DONE;
                        ACK   <= 1'b1;
                        ERR   <= 1'b0;
                        RDATA <= rdBuf;
                    end
                end
                RX: begin
                    if (!ULPI_DIR) begin
                        state <= TURN;
                    end else if (!ULPI_NXT) begin
                        rxCmd     <= rxCmd_s'(ULPI_DATA_I);
                        RXCMD_VLD <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    retryCnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
